// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared screen geometry and coordinate helpers for the shooter datapath.
//   COORD_W         default coordinate width in bits
//   SCREEN_*        default playfield bounds and bullet spawn row
//   coord_t         one screen coordinate
//   popcount8()     number of set bits in an 8-bit vector (slot hit counting)
// ---------------------------------------------------------------------------
package game_pkg;

    localparam int COORD_W        = 10;
    localparam int SCREEN_X_MIN   = 144;
    localparam int SCREEN_X_MAX   = 744;
    localparam int SCREEN_Y_TOP   = 34;
    localparam int SCREEN_SPAWN_Y = 400;
    localparam int MAX_SHOTS      = 8;

    typedef logic [COORD_W-1:0] coord_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/shot_slot.sv
// ---------------------------------------------------------------------------
// shot_slot
// One bullet: valid flag plus X/Y registers.
//   clk, srst          clock and synchronous active-high reset
//   tick               bullet-move strobe (one cycle)
//   load, load_x       spawn a bullet at (load_x, SPAWN_Y); only honoured
//                      while the slot is free
//   tgt_x_lo/hi,
//   tgt_y_hi           target box, all edges inclusive
//   valid, x, y        registered slot state
//   collide            combinational: slot currently overlaps the target
// A collision retires the slot and takes precedence over the tick move and
// the top-of-screen retire. X/Y keep their last value once retired.
// ---------------------------------------------------------------------------
module shot_slot
    import game_pkg::*;
#(
    parameter int CW      = COORD_W,
    parameter int SPAWN_Y = SCREEN_SPAWN_Y,
    parameter int Y_TOP   = SCREEN_Y_TOP
)(
    input  logic          clk,
    input  logic          srst,
    input  logic          tick,
    input  logic          load,
    input  logic [CW-1:0] load_x,
    input  logic [CW-1:0] tgt_x_lo,
    input  logic [CW-1:0] tgt_x_hi,
    input  logic [CW-1:0] tgt_y_hi,
    output logic          valid,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          collide
);

    localparam logic [CW-1:0] RETIRE_Y = CW'(Y_TOP + 1);
    localparam logic [CW-1:0] SPAWN    = CW'(SPAWN_Y);

    logic          valid_reg;
    logic [CW-1:0] x_reg;
    logic [CW-1:0] y_reg;

    // Evaluated on the registered position so the hit lands in the same
    // cycle the renderer already shows the bullet inside the box.
    assign collide = valid_reg
                  && (x_reg >= tgt_x_lo)
                  && (x_reg <= tgt_x_hi)
                  && (y_reg <= tgt_y_hi);

    always_ff @(posedge clk) begin
        if (srst) begin
            valid_reg <= 1'b0;
            x_reg     <= '0;
            y_reg     <= '0;
        end else if (collide) begin
            valid_reg <= 1'b0;
        end else if (valid_reg) begin
            if (tick) begin
                if (y_reg <= RETIRE_Y) begin
                    valid_reg <= 1'b0;
                end else begin
                    y_reg <= y_reg - 1'b1;
                end
            end
        end else if (load) begin
            valid_reg <= 1'b1;
            x_reg     <= load_x;
            y_reg     <= SPAWN;
        end
    end

    assign valid = valid_reg;
    assign x     = x_reg;
    assign y     = y_reg;

endmodule

// File: rtl/shot_engine.sv
// ---------------------------------------------------------------------------
// shot_engine
// Player X movement plus a pool of NUM_SHOTS bullets with target collision.
//   clk, Reset          clock, synchronous active-high reset
//   move_r, move_l      1-cycle pulses, step player right / left
//   fire                1-cycle pulse, spawn a bullet in the lowest free slot
//   tgt_x_lo/hi, tgt_y_hi  target box (inclusive edges)
//   x_position_player   player X
//   shot_valid/x/y      per-slot state, slot i at bit i / [i*CW +: CW]
//   hit                 1-cycle pulse, at least one slot collided
//   collision           sticky hit flag, cleared only by Reset
//   hit_count           saturating number of collided slots
//   fire_drop           1-cycle pulse, a fire request was rejected
// Optional build macro SHOT_COOLDOWN_EN adds parameter COOLDOWN_TICKS and a
// counter that blocks firing until that many bullet ticks have elapsed.
// ---------------------------------------------------------------------------
module shot_engine
    import game_pkg::*;
#(
    parameter int NUM_SHOTS  = 4,
    parameter int CW         = COORD_W,
    parameter int X_MIN      = SCREEN_X_MIN,
    parameter int X_MAX      = SCREEN_X_MAX,
    parameter int X_RESET    = 340,
    parameter int STEP       = 10,
    parameter int MUZZLE_OFF = 15,
    parameter int SPAWN_Y    = SCREEN_SPAWN_Y,
    parameter int Y_TOP      = SCREEN_Y_TOP,
    parameter int TICK_DIV   = 500000,
    parameter int HIT_W      = 8
`ifdef SHOT_COOLDOWN_EN
    ,
    parameter int COOLDOWN_TICKS = 20
`endif
)(
    input  logic                    clk,
    input  logic                    Reset,
    input  logic                    move_r,
    input  logic                    move_l,
    input  logic                    fire,
    input  logic [CW-1:0]           tgt_x_lo,
    input  logic [CW-1:0]           tgt_x_hi,
    input  logic [CW-1:0]           tgt_y_hi,
    output logic [CW-1:0]           x_position_player,
    output logic [NUM_SHOTS-1:0]    shot_valid,
    output logic [NUM_SHOTS*CW-1:0] shot_x,
    output logic [NUM_SHOTS*CW-1:0] shot_y,
    output logic                    hit,
    output logic                    collision,
    output logic [HIT_W-1:0]        hit_count,
    output logic                    fire_drop
);

    localparam int PW = $clog2(TICK_DIV);

    // ------------------------------------------------------------------
    // Bullet-move prescaler
    // ------------------------------------------------------------------
    logic [PW-1:0] presc_reg;
    logic          tick;

    assign tick = (presc_reg == PW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (Reset) begin
            presc_reg <= '0;
        end else if (tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Player X
    // ------------------------------------------------------------------
    logic [CW-1:0] player_x_reg;
    logic [CW-1:0] player_x_next;
    logic [CW:0]   x_plus;

    // One extra bit so the right-hand clamp cannot be fooled by wrap.
    assign x_plus = {1'b0, player_x_reg} + (CW+1)'(STEP);

    always_comb begin
        player_x_next = player_x_reg;
        if (move_r && !move_l) begin
            player_x_next = (x_plus > (CW+1)'(X_MAX)) ? CW'(X_MAX) : x_plus[CW-1:0];
        end else if (move_l && !move_r) begin
            // Compare before subtracting so small X never underflows.
            player_x_next = (player_x_reg < CW'(X_MIN + STEP)) ? CW'(X_MIN)
                                                                 : player_x_reg - CW'(STEP);
        end
    end

    // ------------------------------------------------------------------
    // Slot allocation: lowest-index slot that is free at cycle start.
    // A slot retiring this cycle still reads as valid here, so it only
    // becomes allocatable on the following cycle.
    // ------------------------------------------------------------------
    logic [NUM_SHOTS-1:0] slot_valid;
    logic [NUM_SHOTS-1:0] slot_collide;
    logic [NUM_SHOTS-1:0] alloc_onehot;
    logic                 alloc_found;
    logic                 cooldown_ok;
    logic                 fire_accept;
    logic [CW-1:0]        muzzle_x;

    always_comb begin
        alloc_onehot = '0;
        alloc_found  = 1'b0;
        for (int i = 0; i < NUM_SHOTS; i++) begin
            if (!slot_valid[i] && !alloc_found) begin
                alloc_onehot[i] = 1'b1;
                alloc_found     = 1'b1;
            end
        end
    end

    assign fire_accept = fire && alloc_found && cooldown_ok;
    // Bullet leaves from the player position before this cycle's move.
    assign muzzle_x    = player_x_reg + CW'(MUZZLE_OFF);

`ifdef SHOT_COOLDOWN_EN
    // ------------------------------------------------------------------
    // Fire cooldown, counted in bullet ticks
    // ------------------------------------------------------------------
    localparam int CDW = (COOLDOWN_TICKS < 1) ? 1 : $clog2(COOLDOWN_TICKS + 1);

    logic [CDW-1:0] cooldown_reg;

    assign cooldown_ok = (cooldown_reg == '0);

    always_ff @(posedge clk) begin
        if (Reset) begin
            cooldown_reg <= '0;
        end else if (fire_accept) begin
            cooldown_reg <= CDW'(COOLDOWN_TICKS);
        end else if (tick && (cooldown_reg != '0)) begin
            cooldown_reg <= cooldown_reg - 1'b1;
        end
    end
`else
    assign cooldown_ok = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Bullet slots
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SHOTS; gi++) begin : g_slot
            shot_slot #(
                .CW      (CW),
                .SPAWN_Y (SPAWN_Y),
                .Y_TOP   (Y_TOP)
            ) u_slot (
                .clk      (clk),
                .srst     (Reset),
                .tick     (tick),
                .load     (fire_accept && alloc_onehot[gi]),
                .load_x   (muzzle_x),
                .tgt_x_lo (tgt_x_lo),
                .tgt_x_hi (tgt_x_hi),
                .tgt_y_hi (tgt_y_hi),
                .valid    (slot_valid[gi]),
                .x        (shot_x[gi*CW +: CW]),
                .y        (shot_y[gi*CW +: CW]),
                .collide  (slot_collide[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Hit accounting and registered status outputs
    // ------------------------------------------------------------------
    logic [MAX_SHOTS-1:0] collide_pad;
    logic [HIT_W+3:0]     hit_sum;
    logic [HIT_W-1:0]     hit_count_reg;
    logic [HIT_W-1:0]     hit_count_next;
    logic                 hit_reg;
    logic                 collision_reg;
    logic                 fire_drop_reg;

    always_comb begin
        collide_pad                  = '0;
        collide_pad[NUM_SHOTS-1:0]   = slot_collide;
    end

    // Several slots can collide in one cycle; each one counts.
    assign hit_sum = {4'd0, hit_count_reg} + (HIT_W+4)'(popcount8(collide_pad));
    assign hit_count_next = (|hit_sum[HIT_W+3:HIT_W]) ? {HIT_W{1'b1}} : hit_sum[HIT_W-1:0];

    always_ff @(posedge clk) begin
        if (Reset) begin
            player_x_reg  <= CW'(X_RESET);
            hit_reg       <= 1'b0;
            collision_reg <= 1'b0;
            hit_count_reg <= '0;
            fire_drop_reg <= 1'b0;
        end else begin
            player_x_reg  <= player_x_next;
            hit_reg       <= |slot_collide;
            collision_reg <= collision_reg | (|slot_collide);
            hit_count_reg <= hit_count_next;
            fire_drop_reg <= fire && !fire_accept;
        end
    end

    assign x_position_player = player_x_reg;
    assign shot_valid        = slot_valid;
    assign hit               = hit_reg;
    assign collision         = collision_reg;
    assign hit_count         = hit_count_reg;
    assign fire_drop         = fire_drop_reg;

endmodule

// File: tb/tb_shot_engine.sv
// ---------------------------------------------------------------------------
// tb_shot_engine
// Directed scenarios with fixed expectations, then randomized traffic
// compared every cycle against a behavioural model of the game rules.
// ---------------------------------------------------------------------------
module tb_shot_engine;

    localparam int NS   = 4;
    localparam int CW   = 10;
    localparam int TD   = 4;
    localparam int HW   = 4;
    localparam int HMAX = 15;
    localparam int XMIN = 144;
    localparam int XMAX = 744;
    localparam int XRST = 340;
    localparam int STEP = 10;
    localparam int MUZ  = 15;
    localparam int SPY  = 400;
    localparam int YTOP = 34;
`ifdef SHOT_COOLDOWN_EN
    localparam int CDT  = 2;
    localparam int GAP  = 12;
`else
    localparam int CDT  = 0;
    localparam int GAP  = 0;
`endif

    logic              clk = 1'b0;
    logic              Reset = 1'b0;
    logic              move_r = 1'b0;
    logic              move_l = 1'b0;
    logic              fire = 1'b0;
    logic [CW-1:0]     tgt_x_lo = '1;
    logic [CW-1:0]     tgt_x_hi = '0;
    logic [CW-1:0]     tgt_y_hi = '0;
    logic [CW-1:0]     x_position_player;
    logic [NS-1:0]     shot_valid;
    logic [NS*CW-1:0]  shot_x;
    logic [NS*CW-1:0]  shot_y;
    logic              hit;
    logic              collision;
    logic [HW-1:0]     hit_count;
    logic              fire_drop;

    int checks = 0;
    int failures = 0;

    // Behavioural model of the game state
    int m_px, m_presc, m_cnt, m_cd;
    bit m_hit, m_coll, m_drop;
    bit m_v[NS];
    int m_x[NS];
    int m_y[NS];

    always #5 clk = ~clk;

    shot_engine #(
        .NUM_SHOTS (NS),
        .TICK_DIV  (TD),
        .HIT_W     (HW)
`ifdef SHOT_COOLDOWN_EN
        ,
        .COOLDOWN_TICKS (CDT)
`endif
    ) dut (
        .clk               (clk),
        .Reset             (Reset),
        .move_r            (move_r),
        .move_l            (move_l),
        .fire              (fire),
        .tgt_x_lo          (tgt_x_lo),
        .tgt_x_hi          (tgt_x_hi),
        .tgt_y_hi          (tgt_y_hi),
        .x_position_player (x_position_player),
        .shot_valid        (shot_valid),
        .shot_x            (shot_x),
        .shot_y            (shot_y),
        .hit               (hit),
        .collision         (collision),
        .hit_count         (hit_count),
        .fire_drop         (fire_drop)
    );

    // Game rules for one clock, applied to the model state.
    task automatic model_step(input bit mr, input bit ml, input bit f);
        bit start_v[NS];
        bit tk;
        bit acc;
        int nh;
        int slot;
        if (Reset) begin
            m_px = XRST; m_presc = 0; m_cnt = 0; m_cd = 0;
            m_hit = 0; m_coll = 0; m_drop = 0;
            for (int i = 0; i < NS; i++) begin
                m_v[i] = 0; m_x[i] = 0; m_y[i] = 0;
            end
            return;
        end
        tk = (m_presc == TD - 1);
        m_presc = tk ? 0 : m_presc + 1;
        for (int i = 0; i < NS; i++) start_v[i] = m_v[i];
        nh = 0;
        for (int i = 0; i < NS; i++) begin
            if (m_v[i] && m_x[i] >= int'(tgt_x_lo) && m_x[i] <= int'(tgt_x_hi)
                && m_y[i] <= int'(tgt_y_hi)) begin
                m_v[i] = 0;
                nh++;
            end else if (m_v[i] && tk) begin
                if (m_y[i] <= YTOP + 1) m_v[i] = 0;
                else m_y[i] = m_y[i] - 1;
            end
        end
        m_drop = 0;
        acc = 0;
        slot = -1;
        if (f) begin
            for (int i = 0; i < NS; i++)
                if (!start_v[i] && slot < 0) slot = i;
            if (slot >= 0 && m_cd == 0) begin
                m_v[slot] = 1; m_x[slot] = m_px + MUZ; m_y[slot] = SPY;
                m_cd = CDT;
                acc = 1;
            end else begin
                m_drop = 1;
            end
        end
        if (!acc && tk && m_cd > 0) m_cd--;
        if (mr && !ml) m_px = (m_px + STEP > XMAX) ? XMAX : m_px + STEP;
        else if (ml && !mr) m_px = (m_px - STEP < XMIN) ? XMIN : m_px - STEP;
        m_hit = (nh > 0);
        if (nh > 0) m_coll = 1;
        m_cnt = (m_cnt + nh > HMAX) ? HMAX : m_cnt + nh;
    endtask

    // Called at a falling edge; drives inputs for one rising edge and
    // returns at the next falling edge with inputs idle.
    task automatic step(input bit mr, input bit ml, input bit f);
        move_r = mr; move_l = ml; fire = f;
        model_step(mr, ml, f);
        @(posedge clk);
        @(negedge clk);
        move_r = 0; move_l = 0; fire = 0;
    endtask

    task automatic do_reset();
        Reset = 1;
        step(0, 0, 0);
        Reset = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    task automatic no_target();
        tgt_x_lo = 10'd1023; tgt_x_hi = 10'd0; tgt_y_hi = 10'd0;
    endtask

    task automatic test_reset();
        no_target();
        do_reset();
        checks++; if (x_position_player !== 10'd340) begin failures++; $display("FAIL reset_player got=%0d exp=340", x_position_player); end
        checks++; if (shot_valid !== 4'b0000) begin failures++; $display("FAIL reset_valid got=%b exp=0000", shot_valid); end
        checks++; if (shot_x !== '0 || shot_y !== '0) begin failures++; $display("FAIL reset_xy got_x=%h got_y=%h exp=0", shot_x, shot_y); end
        checks++; if (hit !== 1'b0 || collision !== 1'b0 || fire_drop !== 1'b0) begin failures++; $display("FAIL reset_flags hit=%b coll=%b drop=%b exp=000", hit, collision, fire_drop); end
        checks++; if (hit_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", hit_count); end
        $display("test_reset: player=%0d valid=%b", x_position_player, shot_valid);
    endtask

    task automatic test_move();
        int exp;
        no_target();
        do_reset();
        for (int k = 1; k <= 41; k++) begin
            step(1, 0, 0);
            exp = (XRST + STEP * k > XMAX) ? XMAX : XRST + STEP * k;
            checks++; if (x_position_player !== CW'(exp)) begin failures++; $display("FAIL move_r[%0d] got=%0d exp=%0d", k, x_position_player, exp); end
        end
        for (int k = 1; k <= 61; k++) begin
            step(0, 1, 0);
            exp = (XMAX - STEP * k < XMIN) ? XMIN : XMAX - STEP * k;
            checks++; if (x_position_player !== CW'(exp)) begin failures++; $display("FAIL move_l[%0d] got=%0d exp=%0d", k, x_position_player, exp); end
        end
        step(1, 1, 0);
        checks++; if (x_position_player !== 10'd144) begin failures++; $display("FAIL move_both got=%0d exp=144", x_position_player); end
        $display("test_move: final player=%0d", x_position_player);
    endtask

    task automatic test_fire_retire();
        int life;
        int last_y;
        no_target();
        do_reset();
        step(0, 0, 1);
        checks++; if (shot_valid !== 4'b0001) begin failures++; $display("FAIL fire_valid got=%b exp=0001", shot_valid); end
        checks++; if (shot_x[9:0] !== 10'd355 || shot_y[9:0] !== 10'd400) begin failures++; $display("FAIL fire_pos got=(%0d,%0d) exp=(355,400)", shot_x[9:0], shot_y[9:0]); end
        life = 0;
        last_y = 0;
        while (shot_valid[0] && life < 3000) begin
            life++;
            last_y = int'(shot_y[9:0]);
            step(0, 0, 0);
        end
        checks++; if (shot_valid[0] !== 1'b0 || life < 1460 || life > 1464) begin failures++; $display("FAIL retire_time valid=%b life=%0d exp=1460..1464", shot_valid[0], life); end
        checks++; if (last_y != 35) begin failures++; $display("FAIL retire_y got=%0d exp=35", last_y); end
        checks++; if (hit !== 1'b0 || hit_count !== 4'd0) begin failures++; $display("FAIL retire_nohit hit=%b count=%0d exp=0", hit, hit_count); end
        $display("test_fire_retire: life=%0d last_y=%0d", life, last_y);
    endtask

    task automatic test_pool();
        logic [NS-1:0] exp_v;
        no_target();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            idle(GAP);
            step(0, 0, 1);
            exp_v = (k < 4) ? NS'((1 << (k + 1)) - 1) : 4'b1111;
            checks++; if (shot_valid !== exp_v) begin failures++; $display("FAIL pool_valid[%0d] got=%b exp=%b", k, shot_valid, exp_v); end
            checks++; if (fire_drop !== (k == 4)) begin failures++; $display("FAIL pool_drop[%0d] got=%b exp=%b", k, fire_drop, (k == 4)); end
        end
        step(0, 0, 0);
        checks++; if (fire_drop !== 1'b0 || shot_valid !== 4'b1111) begin failures++; $display("FAIL pool_after drop=%b valid=%b exp=0/1111", fire_drop, shot_valid); end
        $display("test_pool: valid=%b", shot_valid);
    endtask

    task automatic test_hit();
        int n;
        no_target();
        do_reset();
        tgt_x_lo = 10'd310; tgt_x_hi = 10'd340; tgt_y_hi = 10'd124;
        for (int k = 0; k < 4; k++) step(0, 1, 0);
        checks++; if (x_position_player !== 10'd300) begin failures++; $display("FAIL hit_setup got=%0d exp=300", x_position_player); end
        step(0, 0, 1);
        checks++; if (shot_x[9:0] !== 10'd315) begin failures++; $display("FAIL hit_bx got=%0d exp=315", shot_x[9:0]); end
        n = 0;
        while (hit !== 1'b1 && n < 2000) begin
            step(0, 0, 0);
            n++;
        end
        checks++; if (hit !== 1'b1) begin failures++; $display("FAIL hit_timeout hit=%b exp=1", hit); end
        checks++; if (shot_y[9:0] !== 10'd124 || shot_valid[0] !== 1'b0) begin failures++; $display("FAIL hit_pos y=%0d valid=%b exp=124/0", shot_y[9:0], shot_valid[0]); end
        checks++; if (hit_count !== 4'd1 || collision !== 1'b1) begin failures++; $display("FAIL hit_count got=%0d coll=%b exp=1/1", hit_count, collision); end
        idle(3);
        checks++; if (hit !== 1'b0 || collision !== 1'b1 || hit_count !== 4'd1) begin failures++; $display("FAIL hit_after hit=%b coll=%b count=%0d exp=0/1/1", hit, collision, hit_count); end
        $display("test_hit: cycles=%0d count=%0d", n, hit_count);
    endtask

    task automatic test_move_fire();
        no_target();
        do_reset();
        step(1, 0, 1);
        checks++; if (x_position_player !== 10'd350 || shot_x[9:0] !== 10'd355) begin failures++; $display("FAIL mvfire_r player=%0d bx=%0d exp=350/355", x_position_player, shot_x[9:0]); end
        step(1, 1, 0);
        checks++; if (x_position_player !== 10'd350) begin failures++; $display("FAIL mvboth got=%0d exp=350", x_position_player); end
        idle(GAP);
        step(0, 1, 1);
        checks++; if (x_position_player !== 10'd340 || shot_x[19:10] !== 10'd365 || shot_valid !== 4'b0011) begin failures++; $display("FAIL mvfire_l player=%0d bx=%0d valid=%b exp=340/365/0011", x_position_player, shot_x[19:10], shot_valid); end
        $display("test_move_fire: player=%0d valid=%b", x_position_player, shot_valid);
    endtask

`ifdef SHOT_COOLDOWN_EN
    task automatic test_cooldown();
        no_target();
        do_reset();
        step(0, 0, 1);
        idle(2);
        step(0, 0, 1);
        checks++; if (fire_drop !== 1'b1 || shot_valid !== 4'b0001) begin failures++; $display("FAIL cd_reject drop=%b valid=%b exp=1/0001", fire_drop, shot_valid); end
        idle(4);
        step(0, 0, 1);
        checks++; if (fire_drop !== 1'b0 || shot_valid !== 4'b0011) begin failures++; $display("FAIL cd_accept drop=%b valid=%b exp=0/0011", fire_drop, shot_valid); end
        $display("test_cooldown: valid=%b", shot_valid);
    endtask
`endif

    // Random traffic; wide=1 uses a large fixed target so hits pile up
    // and the counter must saturate.
    task automatic test_random(input int cycles, input bit wide);
        logic [NS-1:0]    ev;
        logic [NS*CW-1:0] ex;
        logic [NS*CW-1:0] ey;
        int nbad;
        int lo;
        nbad = 0;
        if (wide) begin
            tgt_x_lo = 10'd150; tgt_x_hi = 10'd800; tgt_y_hi = 10'd390;
        end else begin
            lo = 144 + int'($urandom_range(0, 600));
            tgt_x_lo = CW'(lo); tgt_x_hi = CW'(lo + int'($urandom_range(0, 80)));
            tgt_y_hi = CW'(34 + int'($urandom_range(0, 380)));
        end
        do_reset();
        for (int c = 0; c < cycles; c++) begin
            if (!wide && $urandom_range(0, 399) == 0) begin
                lo = 144 + int'($urandom_range(0, 600));
                tgt_x_lo = CW'(lo); tgt_x_hi = CW'(lo + int'($urandom_range(0, 80)));
                tgt_y_hi = CW'(34 + int'($urandom_range(0, 380)));
            end
            if (!wide && $urandom_range(0, 699) == 0) Reset = 1;
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
            Reset = 0;
            for (int i = 0; i < NS; i++) begin
                ev[i] = m_v[i];
                ex[i*CW +: CW] = CW'(m_x[i]);
                ey[i*CW +: CW] = CW'(m_y[i]);
            end
            checks++;
            if (x_position_player !== CW'(m_px) || shot_valid !== ev || shot_x !== ex || shot_y !== ey
                || hit !== m_hit || collision !== m_coll || hit_count !== HW'(m_cnt) || fire_drop !== m_drop) begin
                failures++;
                nbad++;
                $display("FAIL rand[%0d] got p=%0d v=%b h=%b c=%b n=%0d d=%b x=%h y=%h exp p=%0d v=%b h=%b c=%b n=%0d d=%b x=%h y=%h",
                         c, x_position_player, shot_valid, hit, collision, hit_count, fire_drop, shot_x, shot_y,
                         m_px, ev, m_hit, m_coll, m_cnt, m_drop, ex, ey);
            end
        end
        if (wide) begin
            checks++; if (hit_count !== 4'd15 || collision !== 1'b1) begin failures++; $display("FAIL saturate count=%0d coll=%b exp=15/1", hit_count, collision); end
        end
        $display("test_random: wide=%0d cycles=%0d bad=%0d hits=%0d", wide, cycles, nbad, hit_count);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_move();
        test_fire_retire();
        test_pool();
        test_hit();
        test_move_fire();
`ifdef SHOT_COOLDOWN_EN
        test_cooldown();
`endif
        test_random(4000, 1'b0);
        test_random(1500, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
